motor_ramp: RTL
===============

# motor_ramp

Slew-rate limiter that sits directly upstream of `motor_cntrl`, driving its signed 11-bit `lft`/`rht` commands. It latches target speeds from the steering/PID layer and walks each output toward its target by a fixed step once per prescaler tick. This keeps abrupt command changes, including full sign reversals, from reaching the PWM stage.

## Interface
- `STEP`, 8: magnitude added or subtracted per tick (unsigned, 1..1023).
- `RAMP_DIV`, 1024: clocks per ramp tick (≥2).
- `BRAKE_CYCLES`, 256: zero-hold length on a direction reversal (used only with `MOTOR_RAMP_BRAKE_EN`).
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `lft_tgt` in 11: signed left target.
- `rht_tgt` in 11: signed right target.
- `tgt_vld` in 1: one-cycle strobe that latches both targets.
- `lft` out 11: signed left command to `motor_cntrl`.
- `rht` out 11: signed right command to `motor_cntrl`.
- `ramping` out 1: high whenever state ≠ IDLE.
- `at_tgt` out 1: one-cycle pulse when both outputs reach their latched targets.

## Operation
- **Reset values:** `lft` = `rht` = 0, latched targets = 0, state IDLE, prescaler = 0, brake counter = 0, `ramping` = 0, `at_tgt` = 0.
- **Target latching:** `tgt_vld` latches both targets in any state. Each target is clamped: 11'h400 (−1024) is stored as −1023, so magnitudes stay symmetric for `motor_cntrl`. A new `tgt_vld` overrides any earlier targets and clears the prescaler.
- **Prescaler:** counts 0..`RAMP_DIV`−1 and wraps. It asserts a tick when the count equals `RAMP_DIV`−1. It runs only outside IDLE.
- **Per-channel step on each tick:** compute diff = goal − out in 12-bit sign-extended form, so there is no overflow.
  - diff > `STEP`: out += `STEP`.
  - diff < −`STEP`: out −= `STEP`.
  - otherwise: out = goal.
  - In RAMP the goal is the latched target.
- **States:**
  - IDLE: outputs equal their targets. On `tgt_vld`, go to RAMP if either clamped target differs from its output; otherwise stay in IDLE with no `at_tgt` pulse.
  - RAMP: step on each tick. Go to IDLE when both outputs equal their targets after an update; pulse `at_tgt` in the cycle that state becomes IDLE.
  - BRAKE: exists only with the macro (see Configuration).
- **Channel independence:** channels step independently. A channel already at its goal holds while the other continues.
- **`tgt_vld` coinciding with a tick:** the new targets win. That tick performs no step and the prescaler restarts.
- **Reset mid-ramp:** outputs return to 0 immediately at the clock edge; no `at_tgt` pulse is generated.

## Timing
- `tgt_vld` sampled at edge 0: targets are registered and `ramping` is high from edge 1.
- First output step appears at edge `RAMP_DIV`; later steps follow every `RAMP_DIV` clocks.
- The final step edge makes the outputs equal the targets. On the next edge, `ramping` falls and `at_tgt` rises for exactly one cycle.
- Worst-case ramp time, outside BRAKE: ceil(|diff|/`STEP`)·`RAMP_DIV` clocks for a diff of up to 2046.
- Outputs are registered and change only on tick edges or on `rst`.

## Configuration
- **`MOTOR_RAMP_BRAKE_EN` defined:**
  - A channel whose output is nonzero and whose target has the opposite sign uses goal = 0 in RAMP.
  - Once every reversing channel reaches 0, the block enters BRAKE.
  - In BRAKE, both outputs are held for `BRAKE_CYCLES` clocks, then the block returns to RAMP with the real targets and the prescaler cleared.
  - `tgt_vld` during BRAKE latches new targets but does not shorten the brake.
  - `ramping` stays high through BRAKE.
- **Undefined:** BRAKE state and brake counter are not built. Reversals ramp straight through zero.

## Test plan
Bench parameters: `RAMP_DIV`=4, `STEP`=8, `BRAKE_CYCLES`=6.

1. From reset, `tgt_vld` with lft_tgt=20, rht_tgt=−20 → lft 8, 16, 20 and rht −8, −16, −20 on edges 4, 8, 12; `at_tgt` pulses once at edge 13; `ramping` high for edges 1..12.
2. `tgt_vld` with lft_tgt=11'h400 → lft settles at −1023 (11'h401), never 11'h400.
3. At rest at 20/−20, `tgt_vld` with the same values → `ramping` stays 0 and there is no `at_tgt` pulse.
4. Mid-ramp (lft=16 toward 40), assert `rst` → next edge shows lft=rht=0 and `ramping`=0; no `at_tgt` pulse.
5. Second `tgt_vld` (lft_tgt=0) on the same cycle as a tick while at lft=16 → no step on that edge; lft reaches 8 four clocks later, then 0.
6. With `MOTOR_RAMP_BRAKE_EN`, at lft=16, `tgt_vld` lft_tgt=−16 → lft goes 8, 0, then holds 0 for 6 clocks, then steps −8, −16 at 4-clock spacing; without the macro, lft goes 8, 0, −8, −16 with no hold.

Source files
------------

// File: rtl/motor_ramp.sv
// Slew-rate limiter feeding motor_cntrl: walks lft/rht toward latched targets by STEP per prescaler tick.
// Optional zero-hold on direction reversal is built when MOTOR_RAMP_BRAKE_EN is defined.

module motor_ramp_lane #(
  parameter int STEP = 8
) (
  input  logic signed [10:0] cur,
  input  logic signed [10:0] goal,
  output logic signed [10:0] nxt
);
  localparam logic signed [11:0] STEP_S = 12'(STEP);

  logic signed [11:0] diff;

  // 12-bit sign-extended difference cannot overflow for any pair of 11-bit values
  always_comb begin
    diff = {goal[10], goal} - {cur[10], cur};
    nxt  = goal;
    if (diff > STEP_S)
      nxt = cur + 11'(STEP);
    else if (diff < -STEP_S)
      nxt = cur - 11'(STEP);
  end
endmodule

module motor_ramp #(
  parameter int STEP         = 8,
  parameter int RAMP_DIV     = 1024,
  parameter int BRAKE_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [10:0] lft_tgt,
  input  logic signed [10:0] rht_tgt,
  input  logic               tgt_vld,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               ramping,
  output logic               at_tgt
);
  localparam int NUM_LANES = 2;
  localparam int PW        = $clog2(RAMP_DIV);

  typedef logic [NUM_LANES-1:0][10:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP
`ifdef MOTOR_RAMP_BRAKE_EN
    , BRAKE
`endif
  } state_t;

  if (RAMP_DIV < 2 || STEP < 1 || STEP > 1023 || BRAKE_CYCLES < 1) begin : g_param_chk
    $error("motor_ramp: illegal parameter value");
  end

  state_t        state;
  lane_vec_t     out_q, tgt_q, tgt_in, goal, nxt;
  logic [PW-1:0] pre;
  logic          tick;
  logic [1:0]    done_pipe;

  // -1024 has no positive mirror, so keep magnitudes symmetric
  function automatic logic [10:0] clamp(input logic [10:0] v);
    return (v == 11'h400) ? 11'h401 : v;
  endfunction

  assign tgt_in = {clamp(rht_tgt), clamp(lft_tgt)};
  assign tick   = (pre == PW'(RAMP_DIV - 1));
  assign lft    = out_q[0];
  assign rht    = out_q[1];
  assign at_tgt = done_pipe[1];

`ifdef MOTOR_RAMP_BRAKE_EN
  localparam int BW = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;

  logic [BW-1:0]        bcnt;
  logic [NUM_LANES-1:0] rev, rev_live;
  logic                 brk_go;

  // brake once every reversing channel lands on zero this tick
  assign brk_go = (|rev) && !(|rev_live);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
`ifdef MOTOR_RAMP_BRAKE_EN
    assign rev[i]      = (out_q[i] != '0) && (tgt_q[i] != '0) && (out_q[i][10] != tgt_q[i][10]);
    assign goal[i]     = rev[i] ? '0 : tgt_q[i];
    assign rev_live[i] = rev[i] && (nxt[i] != '0);
`else
    assign goal[i] = tgt_q[i];
`endif
    motor_ramp_lane #(.STEP(STEP)) u_lane (
      .cur  (out_q[i]),
      .goal (goal[i]),
      .nxt  (nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_q     <= '0;
      tgt_q     <= '0;
      pre       <= '0;
      done_pipe <= '0;
      ramping   <= 1'b0;
`ifdef MOTOR_RAMP_BRAKE_EN
      bcnt      <= '0;
`endif
    end else begin
      done_pipe <= {done_pipe[0], 1'b0};
      ramping   <= (state != IDLE);
      if (tgt_vld) begin
        // new targets win over a coinciding tick; prescaler restarts
        tgt_q <= tgt_in;
        pre   <= '0;
        if (state == IDLE && tgt_in != out_q)
          state <= RAMP;
      end else if (state == RAMP) begin
        if (tick) begin
          pre   <= '0;
          out_q <= nxt;
          if (nxt == tgt_q) begin
            state        <= IDLE;
            done_pipe[0] <= 1'b1;
          end
`ifdef MOTOR_RAMP_BRAKE_EN
          else if (brk_go) begin
            state <= BRAKE;
            bcnt  <= '0;
          end
`endif
        end else begin
          pre <= pre + 1'b1;
        end
      end
`ifdef MOTOR_RAMP_BRAKE_EN
      if (state == BRAKE) begin
        if (bcnt == BW'(BRAKE_CYCLES - 1)) begin
          state <= RAMP;
          pre   <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
`endif
    end
  end
endmodule
